// File: rtl/notch_sd_arbiter.sv
// Read/write arbiter in front of an Avalon-MM SDRAM master port.
// Define NOTCH_SD_ARBITER_STATS_EN to add rd_count / wr_count outputs.
module notch_sd_arbiter #(
  parameter int ADDR_W          = 24,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] sdaddress,
  output logic              sdread,
  output logic              sdwrite,
  output logic [31:0]       sdwritedata,
  input  logic [31:0]       sdreaddata,
  input  logic              sdreaddatavalid,
  input  logic              sdwaitrequest,
  output logic [CNT_W-1:0]  outstanding,
`ifdef NOTCH_SD_ARBITER_STATS_EN
  output logic              err_spurious,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`else
  output logic              err_spurious
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT =
    CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } state_t;

  state_t state;
  state_t state_nxt;

  logic last_wr;
  logic rd_elig;
  logic wr_elig;
  logic grant_rd;
  logic grant_wr;
  logic rd_done;
  logic wr_done;
  logic rd_ret;
  logic rd_spur;

  // Masking with the ack stops a requester that still holds its
  // req during the ack cycle from being granted twice.
  always_comb begin
    state_nxt = state;
    rd_elig   = 1'b0;
    wr_elig   = 1'b0;
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    rd_done   = 1'b0;
    wr_done   = 1'b0;
    unique case (state)
      IDLE: begin
        rd_elig  = rd_req && !rd_ack
                   && (outstanding < MAX_CNT);
        wr_elig  = wr_req && !wr_ack;
        grant_rd = rd_elig && (!wr_elig || last_wr);
        grant_wr = wr_elig && !grant_rd;
        if (grant_rd)
          state_nxt = RD;
        else if (grant_wr)
          state_nxt = WR;
      end
      RD: begin
        if (!sdwaitrequest) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WR: begin
        if (!sdwaitrequest) begin
          wr_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sdread      <= 1'b0;
      sdwrite     <= 1'b0;
      sdaddress   <= '0;
      sdwritedata <= '0;
      rd_ack      <= 1'b0;
      wr_ack      <= 1'b0;
      last_wr     <= 1'b1;
    end else begin
      rd_ack <= rd_done;
      wr_ack <= wr_done;
      if (grant_rd) begin
        sdread    <= 1'b1;
        sdaddress <= rd_addr;
      end else if (grant_wr) begin
        sdwrite     <= 1'b1;
        sdaddress   <= wr_addr;
        sdwritedata <= wr_data;
      end
      if (rd_done) begin
        sdread  <= 1'b0;
        last_wr <= 1'b0;
      end
      if (wr_done) begin
        sdwrite <= 1'b0;
        last_wr <= 1'b1;
      end
    end
  end

  // Data with nothing outstanding is dropped and flagged.
  assign rd_ret  = sdreaddatavalid && (outstanding != '0);
  assign rd_spur = sdreaddatavalid && (outstanding == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding  <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      err_spurious <= 1'b0;
    end else begin
      rd_valid <= rd_ret;
      rd_data  <= sdreaddata;
      if (rd_spur)
        err_spurious <= 1'b1;
      unique case ({rd_done, rd_ret})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

`ifdef NOTCH_SD_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_done)
        rd_count <= rd_count + 32'd1;
      if (wr_done)
        wr_count <= wr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_notch_sd_arbiter.sv
// Scoreboard bench for notch_sd_arbiter: directed traffic,
// command and read-data queues checked by a negedge monitor.
module tb_notch_sd_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0;
  logic [23:0] rd_addr = '0;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        wr_req = 1'b0;
  logic [23:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_ack;
  logic [23:0] sdaddress;
  logic        sdread;
  logic        sdwrite;
  logic [31:0] sdwritedata;
  logic [31:0] sdreaddata = '0;
  logic        sdreaddatavalid = 1'b0;
  logic        sdwaitrequest = 1'b0;
  logic [3:0]  outstanding;
  logic        err_spurious;
`ifdef NOTCH_SD_ARBITER_STATS_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          wr;
    logic [23:0] addr;
    logic [31:0] data;
  } cmd_t;

  cmd_t        exp_cmd[$];
  logic [31:0] exp_rd[$];
  bit          prev_cmd = 1'b0;

  notch_sd_arbiter dut (
    .clk(clk),
    .reset(reset),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_ack(rd_ack),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ack(wr_ack),
    .sdaddress(sdaddress),
    .sdread(sdread),
    .sdwrite(sdwrite),
    .sdwritedata(sdwritedata),
    .sdreaddata(sdreaddata),
    .sdreaddatavalid(sdreaddatavalid),
    .sdwaitrequest(sdwaitrequest),
    .outstanding(outstanding),
`ifdef NOTCH_SD_ARBITER_STATS_EN
    .err_spurious(err_spurious),
    .rd_count(rd_count),
    .wr_count(wr_count)
`else
    .err_spurious(err_spurious)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every new command and every rd_valid pops a queue.
  always @(negedge clk) begin
    if (reset) begin
      prev_cmd = 1'b0;
    end else begin
      if ((sdread || sdwrite) && !prev_cmd) begin
        checks++;
        if (exp_cmd.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected: rd=%b wr=%b addr=%h",
                   sdread, sdwrite, sdaddress);
        end else begin
          cmd_t e;
          e = exp_cmd.pop_front();
          if (sdwrite !== e.wr || sdread !== !e.wr
              || sdaddress !== e.addr
              || (e.wr && sdwritedata !== e.data)) begin
            errors++;
            $display("FAIL cmd: got wr=%b rd=%b a=%h d=%h want wr=%b a=%h d=%h",
                     sdwrite, sdread, sdaddress, sdwritedata,
                     e.wr, e.addr, e.data);
          end
        end
      end
      prev_cmd = sdread || sdwrite;
      if (rd_valid) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got %h want none", rd_data);
        end else begin
          logic [31:0] d;
          d = exp_rd.pop_front();
          if (rd_data !== d) begin
            errors++;
            $display("FAIL rd_data: got %h want %h", rd_data, d);
          end
        end
      end
    end
  end

  task automatic wait_ack(bit wr, string nm);
    int n = 0;
    while (!(wr ? wr_ack : rd_ack) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL %s: ack got 0 want 1 (timeout)", nm);
    end
  endtask

  task automatic do_read(logic [23:0] a);
    exp_cmd.push_back('{1'b0, a, 32'h0});
    @(negedge clk);
    rd_req  = 1'b1;
    rd_addr = a;
    wait_ack(1'b0, "rd_ack");
    rd_req = 1'b0;
  endtask

  task automatic do_write(logic [23:0] a, logic [31:0] d);
    exp_cmd.push_back('{1'b1, a, d});
    @(negedge clk);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    wait_ack(1'b1, "wr_ack");
    wr_req = 1'b0;
  endtask

  task automatic ret(logic [31:0] d, bit expect_out);
    if (expect_out)
      exp_rd.push_back(d);
    @(negedge clk);
    sdreaddatavalid = 1'b1;
    sdreaddata      = d;
    @(negedge clk);
    sdreaddatavalid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nr;
    int nw;
    int n;
    bit stall_ok;

    repeat (2) @(negedge clk);
    chk("rst_sdread", sdread, 0);
    chk("rst_sdwrite", sdwrite, 0);
    chk("rst_sdaddress", sdaddress, 0);
    chk("rst_acks", {rd_ack, wr_ack, rd_valid}, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_spurious, 0);
    reset = 1'b0;

    // Single write with 1-cycle command latency.
    exp_cmd.push_back('{1'b1, 24'h000100, 32'hDEADBEEF});
    @(negedge clk);
    wr_req  = 1'b1;
    wr_addr = 24'h000100;
    wr_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_latency", sdwrite, 1);
    chk("wr_early_ack", wr_ack, 0);
    @(negedge clk);
    chk("wr_ack_pulse", {wr_ack, sdwrite}, 2'b10);
    wr_req = 1'b0;

    // Contention: both held, expect RD,WR,RD,WR...
    for (int i = 0; i < 4; i++) begin
      exp_cmd.push_back('{1'b0, 24'h000200, 32'h0});
      exp_cmd.push_back('{1'b1, 24'h000300, 32'h11112222});
    end
    @(negedge clk);
    rd_req  = 1'b1;
    rd_addr = 24'h000200;
    wr_req  = 1'b1;
    wr_addr = 24'h000300;
    wr_data = 32'h11112222;
    nr = 0;
    nw = 0;
    n  = 0;
    while (nr + nw < 8 && n < 100) begin
      @(negedge clk);
      n++;
      if (rd_ack) nr++;
      if (wr_ack) nw++;
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    chk("cont_rd_acks", nr, 4);
    chk("cont_wr_acks", nw, 4);
    chk("cont_outstanding", outstanding, 4);
    for (int i = 0; i < 4; i++)
      ret(32'hA0A0_0000 + i, 1'b1);
    chk("drain_outstanding", outstanding, 0);

    // Backpressure during a read.
    exp_cmd.push_back('{1'b0, 24'h000400, 32'h0});
    @(negedge clk);
    sdwaitrequest = 1'b1;
    rd_req  = 1'b1;
    rd_addr = 24'h000400;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {sdread, rd_ack, 8'h0, sdaddress},
          {1'b1, 1'b0, 8'h0, 24'h000400});
    end
    sdwaitrequest = 1'b0;
    @(negedge clk);
    chk("bp_release", {rd_ack, sdread}, 2'b10);
    rd_req = 1'b0;
    ret(32'hB0B0_0001, 1'b1);

    // Outstanding limit: reads stall, writes pass.
    for (int i = 0; i < 8; i++)
      do_read(24'h000800 + 24'(i));
    chk("lim_full", outstanding, 8);
    exp_cmd.push_back('{1'b1, 24'h000A00, 32'hCAFEF00D});
    @(negedge clk);
    rd_req  = 1'b1;
    rd_addr = 24'h000900;
    wr_req  = 1'b1;
    wr_addr = 24'h000A00;
    wr_data = 32'hCAFEF00D;
    wait_ack(1'b1, "lim_wr_ack");
    wr_req = 1'b0;
    stall_ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (sdread || rd_ack) stall_ok = 1'b0;
    end
    chk("lim_rd_stall", stall_ok, 1);
    exp_cmd.push_back('{1'b0, 24'h000900, 32'h0});
    ret(32'h5A5A_0001, 1'b1);
    wait_ack(1'b0, "lim_rd_ack");
    rd_req = 1'b0;
    chk("lim_refill", outstanding, 8);
    for (int i = 0; i < 8; i++)
      ret(32'hC0C0_0000 + i, 1'b1);
    chk("lim_drained", outstanding, 0);

    // Spurious read data.
    ret(32'hBAD0_0BAD, 1'b0);
    chk("spur_err", err_spurious, 1);
    chk("spur_outstanding", outstanding, 0);

    // 3 reads, 2 writes after a clean reset.
    do_reset();
    chk("rst2_err", err_spurious, 0);
    do_read(24'h000010);
    do_write(24'h000020, 32'h0000_0020);
    do_read(24'h000011);
    do_write(24'h000021, 32'h0000_0021);
    do_read(24'h000012);
    chk("mix_outstanding", outstanding, 3);
`ifdef NOTCH_SD_ARBITER_STATS_EN
    chk("stat_rd_count", rd_count, 3);
    chk("stat_wr_count", wr_count, 2);
`endif

    // Asynchronous reset in the middle of a stalled read.
    exp_cmd.push_back('{1'b0, 24'h000777, 32'h0});
    @(negedge clk);
    sdwaitrequest = 1'b1;
    rd_req  = 1'b1;
    rd_addr = 24'h000777;
    @(negedge clk);
    chk("mid_rd_active", sdread, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_cmd", {sdread, sdwrite, rd_ack, wr_ack}, 0);
    chk("async_addr", sdaddress, 0);
    chk("async_wdata", sdwritedata, 0);
    chk("async_rd", {rd_valid, err_spurious}, 0);
    chk("async_rdata", rd_data, 0);
    chk("async_outstanding", outstanding, 0);
`ifdef NOTCH_SD_ARBITER_STATS_EN
    chk("async_counts", rd_count | wr_count, 0);
`endif
    rd_req = 1'b0;
    sdwaitrequest = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    stall_ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rd_ack || sdread) stall_ok = 1'b0;
    end
    chk("abandon_no_ack", stall_ok, 1);
    ret(32'h7777_7777, 1'b0);
    chk("late_data_err", err_spurious, 1);

    repeat (2) @(negedge clk);
    chk("cmd_queue_empty", exp_cmd.size(), 0);
    chk("rd_queue_empty", exp_rd.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
